eros_pwr_ctrl: RTL and testbench

Power-sequencing controller for the EROS cluster. It watches the per-hart sleep flags. When every hart sleeps and automatic power-down is enabled, it steps the cluster through the following, in strict order:

- gate the cluster clock (drives the wrapper clock-gate `en_i`);
- put selected memory banks into retention;
- power-gate the remaining banks, waiting for each bank's power-switch acknowledge.

On a wake-up request it reverses the sequence. It sits beside the cluster wrapper and is configured and monitored through CSR-driven inputs and outputs.

---
 rtl/eros_pwr_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_eros_pwr_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eros_pwr_ctrl.sv
// EROS cluster power-sequencing controller.
// Gates clock, retains and power-gates banks on sleep; reverses on wake.
module eros_pwr_ctrl #(
  parameter int NHARTS        = 3,
  parameter int N_BANKS       = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NHARTS-1:0]  sleep_i,
  input  logic               auto_en_i,
  input  logic [N_BANKS-1:0] bank_ret_mask_i,
  input  logic               wakeup_i,
  output logic               clk_en_o,
  output logic [N_BANKS-1:0] set_retentive_no,
  output logic [N_BANKS-1:0] pwrgate_no,
  input  logic [N_BANKS-1:0] pwrgate_ack_ni,
  output logic [2:0]         state_o,
  output logic               off_o,
  output logic               timeout_o,
  input  logic               timeout_clr_i
);

  localparam int CMAX =
    (SETTLE_CYCLES > ACK_TIMEOUT) ?
    SETTLE_CYCLES : ACK_TIMEOUT;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SETTLE_END =
    CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] ACK_END =
    CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT = '1;

  typedef enum logic [2:0] {
    ACTIVE  = 3'd0,
    CLK_OFF = 3'd1,
    RET_ON  = 3'd2,
    PWR_OFF = 3'd3,
    OFF     = 3'd4,
    PWR_ON  = 3'd5,
    RET_OFF = 3'd6,
    CLK_ON  = 3'd7
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0]      cnt_q;
  logic               arm_q;
  logic [N_BANKS-1:0] mask_q;
  logic [N_BANKS-1:0] mask_d;

  logic all_sleep;
  logic enter;
  logic settle_done;
  logic ack_end;
  logic gated_acked;
  logic released;
  logic set_to;
  logic ret_hold;
  logic pg_hold;
  logic clk_on;

  assign all_sleep   = &sleep_i;
  assign enter       = auto_en_i & all_sleep &
                       ~wakeup_i & arm_q;
  assign settle_done = (cnt_q == SETTLE_END);
  assign ack_end     = (cnt_q == ACK_END);
  // retained banks never assert an ack, so they count as done
  assign gated_acked = &(~pwrgate_ack_ni | mask_q);
  assign released    = &pwrgate_ack_ni;
  assign state_o     = state_q;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    set_to  = 1'b0;
    unique case (state_q)
      ACTIVE: begin
        if (enter) begin
          state_d = CLK_OFF;
          mask_d  = bank_ret_mask_i;
        end
      end
      CLK_OFF: begin
        if (wakeup_i)
          state_d = CLK_ON;
        else if (settle_done)
          state_d = RET_ON;
      end
      RET_ON: begin
        if (wakeup_i)
          state_d = RET_OFF;
        else if (settle_done)
          state_d = PWR_OFF;
      end
      PWR_OFF: begin
        if (gated_acked) begin
          state_d = OFF;
        end else if (ack_end) begin
          state_d = PWR_ON;
          set_to  = 1'b1;
        end
      end
      OFF: begin
        if (wakeup_i)
          state_d = PWR_ON;
      end
      PWR_ON: begin
        if (released) begin
          state_d = RET_OFF;
        end else if (ack_end) begin
          state_d = RET_OFF;
          set_to  = 1'b1;
        end
      end
      RET_OFF: begin
        if (settle_done)
          state_d = CLK_ON;
      end
      CLK_ON: begin
        state_d = ACTIVE;
      end
    endcase
  end

  always_comb begin
    ret_hold = 1'b0;
    pg_hold  = 1'b0;
    clk_on   = 1'b0;
    unique case (1'b1)
      (state_d == ACTIVE),
      (state_d == CLK_ON): clk_on = 1'b1;
      (state_d == RET_ON),
      (state_d == PWR_ON): ret_hold = 1'b1;
      (state_d == PWR_OFF),
      (state_d == OFF): begin
        ret_hold = 1'b1;
        pg_hold  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= ACTIVE;
      cnt_q            <= '0;
      arm_q            <= 1'b1;
      mask_q           <= '1;
      clk_en_o         <= 1'b1;
      set_retentive_no <= '1;
      pwrgate_no       <= '1;
      off_o            <= 1'b0;
      timeout_o        <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (cnt_q != CNT_SAT)
        cnt_q <= cnt_q + 1'b1;
      if (!all_sleep)
        arm_q <= 1'b1;
      else if (state_q == CLK_ON)
        arm_q <= 1'b0;
      if (set_to)
        timeout_o <= 1'b1;
      else if (timeout_clr_i)
        timeout_o <= 1'b0;
      clk_en_o         <= clk_on;
      set_retentive_no <= ret_hold ? ~mask_d : '1;
      pwrgate_no       <= pg_hold ? mask_d : '1;
      off_o            <= (state_d == OFF);
    end
  end

endmodule

// File: tb/tb_eros_pwr_ctrl.sv
// Scoreboard bench for eros_pwr_ctrl.
// Reference model predicts outputs; monitor compares after each edge.
module tb_eros_pwr_ctrl;

  localparam int NH = 3;
  localparam int NB = 2;
  localparam int SC = 4;
  localparam int AT = 255;

  localparam int S_ACTIVE  = 0;
  localparam int S_CLK_OFF = 1;
  localparam int S_RET_ON  = 2;
  localparam int S_PWR_OFF = 3;
  localparam int S_OFF     = 4;
  localparam int S_PWR_ON  = 5;
  localparam int S_RET_OFF = 6;
  localparam int S_CLK_ON  = 7;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [NH-1:0] sleep_i = '0;
  logic          auto_en_i = 1'b1;
  logic [NB-1:0] bank_ret_mask_i = 2'b01;
  logic          wakeup_i = 1'b0;
  logic          timeout_clr_i = 1'b0;
  logic [NB-1:0] pwrgate_ack_ni;
  logic          clk_en_o;
  logic [NB-1:0] set_retentive_no;
  logic [NB-1:0] pwrgate_no;
  logic [2:0]    state_o;
  logic          off_o;
  logic          timeout_o;

  always #5 clk_i = ~clk_i;

  eros_pwr_ctrl #(
    .NHARTS(NH), .N_BANKS(NB),
    .SETTLE_CYCLES(SC), .ACK_TIMEOUT(AT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .sleep_i(sleep_i), .auto_en_i(auto_en_i),
    .bank_ret_mask_i(bank_ret_mask_i),
    .wakeup_i(wakeup_i), .clk_en_o(clk_en_o),
    .set_retentive_no(set_retentive_no),
    .pwrgate_no(pwrgate_no),
    .pwrgate_ack_ni(pwrgate_ack_ni),
    .state_o(state_o), .off_o(off_o),
    .timeout_o(timeout_o),
    .timeout_clr_i(timeout_clr_i)
  );

  // power-switch model: ack follows switch control after ack_delay edges
  int            ack_delay = 0;
  bit            ack_stuck = 1'b0;
  logic [NB-1:0] sh [8];

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 8; i++) sh[i] <= '1;
    end else begin
      sh[0] <= pwrgate_no;
      for (int i = 1; i < 8; i++) sh[i] <= sh[i-1];
    end
  end

  always_comb begin
    pwrgate_ack_ni = '1;
    if (!ack_stuck)
      pwrgate_ack_ni = (ack_delay == 0) ?
        pwrgate_no : sh[ack_delay-1];
  end

  typedef struct {
    int            st;
    logic          clk_en;
    logic [NB-1:0] ret_n;
    logic [NB-1:0] pg_n;
    logic          off;
    logic          to;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  int            m_st;
  int            m_cnt;
  bit            m_arm;
  bit            m_to;
  logic [NB-1:0] m_mask;

  task automatic model_reset();
    m_st   = S_ACTIVE;
    m_cnt  = 0;
    m_arm  = 1'b1;
    m_to   = 1'b0;
    m_mask = '1;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    bit held;
    e.st     = m_st;
    e.clk_en = (m_st == S_ACTIVE) || (m_st == S_CLK_ON);
    held     = (m_st >= S_RET_ON) && (m_st <= S_PWR_ON);
    e.ret_n  = held ? ~m_mask : '1;
    e.pg_n   = (m_st == S_PWR_OFF || m_st == S_OFF) ?
               m_mask : '1;
    e.off    = (m_st == S_OFF);
    e.to     = m_to;
    return e;
  endfunction

  task automatic model_step();
    int nx;
    bit all_sl;
    bit to_set;
    bit acked;
    bit rel;
    nx     = m_st;
    to_set = 1'b0;
    all_sl = &sleep_i;
    acked  = 1'b1;
    for (int b = 0; b < NB; b++)
      if (!m_mask[b] && pwrgate_ack_ni[b]) acked = 1'b0;
    rel = &pwrgate_ack_ni;
    case (m_st)
      S_ACTIVE:
        if (auto_en_i && all_sl && !wakeup_i && m_arm) begin
          nx = S_CLK_OFF;
          m_mask = bank_ret_mask_i;
        end
      S_CLK_OFF:
        if (wakeup_i) nx = S_CLK_ON;
        else if (m_cnt == SC - 1) nx = S_RET_ON;
      S_RET_ON:
        if (wakeup_i) nx = S_RET_OFF;
        else if (m_cnt == SC - 1) nx = S_PWR_OFF;
      S_PWR_OFF:
        if (acked) nx = S_OFF;
        else if (m_cnt == AT - 1) begin
          nx = S_PWR_ON;
          to_set = 1'b1;
        end
      S_OFF:
        if (wakeup_i) nx = S_PWR_ON;
      S_PWR_ON:
        if (rel) nx = S_RET_OFF;
        else if (m_cnt == AT - 1) begin
          nx = S_RET_OFF;
          to_set = 1'b1;
        end
      S_RET_OFF:
        if (m_cnt == SC - 1) nx = S_CLK_ON;
      default:
        nx = S_ACTIVE;
    endcase
    if (!all_sl) m_arm = 1'b1;
    else if (m_st == S_CLK_ON) m_arm = 1'b0;
    if (to_set) m_to = 1'b1;
    else if (timeout_clr_i) m_to = 1'b0;
    m_cnt = (nx != m_st) ? 0 : m_cnt + 1;
    m_st  = nx;
  endtask

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  exp_t mon_e;
  always @(posedge clk_i) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (int'(state_o) == mon_e.st &&
          clk_en_o == mon_e.clk_en &&
          set_retentive_no == mon_e.ret_n &&
          pwrgate_no == mon_e.pg_n &&
          off_o == mon_e.off &&
          timeout_o == mon_e.to)
        n_pass++;
      else
        $display({"FAIL cycle @%0t: st=%0d clk_en=%b ret_n=%b",
                  " pg_n=%b off=%b to=%b; expected st=%0d",
                  " clk_en=%b ret_n=%b pg_n=%b off=%b to=%b"},
                 $time, state_o, clk_en_o, set_retentive_no,
                 pwrgate_no, off_o, timeout_o, mon_e.st,
                 mon_e.clk_en, mon_e.ret_n, mon_e.pg_n,
                 mon_e.off, mon_e.to);
    end
  end

  task automatic step();
    #1;
    model_step();
    sb.push_back(model_out());
    @(negedge clk_i);
  endtask

  task automatic wait_state(int s, int budget);
    int n = 0;
    while (int'(state_o) != s && n < budget) begin
      step();
      n++;
    end
    chk($sformatf("reach_state_%0d", s), int'(state_o), s);
  endtask

  task automatic count_state(int s, output int n);
    n = 0;
    while (int'(state_o) == s && n < 600) begin
      step();
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_state", int'(state_o), 0);
    chk("rst_clk_en", int'(clk_en_o), 1);
    chk("rst_ret_n", int'(set_retentive_no), 3);
    chk("rst_pg_n", int'(pwrgate_no), 3);
    chk("rst_off", int'(off_o), 0);
    chk("rst_timeout", int'(timeout_o), 0);
    rst_ni = 1'b1;

    sleep_i = 3'b111;
    wait_state(S_OFF, 50);
    chk("off_ret_n", int'(set_retentive_no), 2);
    chk("off_pg_n", int'(pwrgate_no), 1);
    chk("off_flag", int'(off_o), 1);
    chk("off_clk_en", int'(clk_en_o), 0);

    ack_delay = 3;
    repeat (6) step();
    wakeup_i = 1'b1;
    step();
    wakeup_i = 1'b0;
    count_state(S_PWR_ON, n);
    chk("pwr_on_cycles", n, 4);
    count_state(S_RET_OFF, n);
    chk("ret_off_cycles", n, 4);
    chk("clk_on_state", int'(state_o), S_CLK_ON);
    chk("clk_on_clk_en", int'(clk_en_o), 1);
    step();
    chk("back_active", int'(state_o), S_ACTIVE);
    repeat (8) step();
    chk("no_reentry_1", int'(state_o), S_ACTIVE);

    ack_delay = 0;
    sleep_i = 3'b000;
    step();
    sleep_i = 3'b111;
    step();
    chk("abort_enter", int'(state_o), S_CLK_OFF);
    step();
    wakeup_i = 1'b1;
    step();
    wakeup_i = 1'b0;
    chk("abort_clk_on", int'(state_o), S_CLK_ON);
    step();
    chk("abort_active", int'(state_o), S_ACTIVE);
    repeat (8) step();
    chk("no_reentry_2", int'(state_o), S_ACTIVE);
    sleep_i = 3'b000;
    step();
    sleep_i = 3'b111;
    step();
    chk("rearm_enter", int'(state_o), S_CLK_OFF);

    ack_stuck = 1'b1;
    wait_state(S_PWR_OFF, 50);
    repeat (AT) step();
    chk("to_state", int'(state_o), S_PWR_ON);
    chk("to_flag", int'(timeout_o), 1);
    step();
    timeout_clr_i = 1'b1;
    step();
    timeout_clr_i = 1'b0;
    chk("to_clear", int'(timeout_o), 0);
    ack_stuck = 1'b0;
    wait_state(S_ACTIVE, 50);

    sleep_i = 3'b000;
    step();
    bank_ret_mask_i = 2'b11;
    sleep_i = 3'b111;
    wait_state(S_PWR_OFF, 50);
    step();
    chk("allret_state", int'(state_o), S_OFF);
    chk("allret_pg_n", int'(pwrgate_no), 3);
    chk("allret_ret_n", int'(set_retentive_no), 0);
    wakeup_i = 1'b1;
    step();
    wakeup_i = 1'b0;
    wait_state(S_ACTIVE, 50);

    sleep_i = 3'b000;
    step();
    bank_ret_mask_i = 2'b10;
    sleep_i = 3'b111;
    wait_state(S_OFF, 50);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_state", int'(state_o), 0);
    chk("arst_clk_en", int'(clk_en_o), 1);
    chk("arst_pg_n", int'(pwrgate_no), 3);
    chk("arst_ret_n", int'(set_retentive_no), 3);
    chk("arst_off", int'(off_o), 0);
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    repeat (3000) begin
      sleep_i = ($urandom_range(0, 3) == 0) ?
                NH'($urandom) : 3'b111;
      auto_en_i = ($urandom_range(0, 7) != 0);
      bank_ret_mask_i = NB'($urandom);
      wakeup_i = ($urandom_range(0, 15) == 0);
      timeout_clr_i = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 63) == 0) begin
        ack_delay = $urandom_range(0, 5);
        ack_stuck = ($urandom_range(0, 9) == 0);
      end
      step();
    end

    n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
